wb_write_arbiter: RTL

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: single-cycle A port has strict priority over a 4-entry B FIFO.
// Define WB_BYPASS_EN to build the pending-write bypass lookup (qry_*); otherwise qry_* are tied to 0.
module wb_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data,
    output logic [2:0]  b_count,
    input  logic [4:0]  qry_reg,
    output logic        qry_hit,
    output logic [31:0] qry_data
);
    localparam int         PW   = $clog2(DEPTH);
    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [2:0]    count;
    logic          a_eff;
    logic          push;
    logic          pop;

    assign a_eff   = a_valid && (a_rd != 5'd0);
    assign b_ready = !reset && (count < FULL);
    // rd=0 transfers complete the handshake but never occupy a slot
    assign push    = b_valid && b_ready && (b_rd != 5'd0);
    assign pop     = !a_eff && (count != 3'd0);
    assign b_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_reg  <= 5'd0;
            wr_data <= 32'd0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= 3'd0;
        end else begin
            if (a_eff) begin
                wr_en   <= 1'b1;
                wr_reg  <= a_rd;
                wr_data <= a_data;
            end else if (pop) begin
                wr_en   <= 1'b1;
                wr_reg  <= fifo_rd[rptr];
                wr_data <= fifo_data[rptr];
            end else begin
                wr_en <= 1'b0;
            end
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only valid inside the rptr/count window
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= b_rd;
            fifo_data[wptr] <= b_data;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        qry_hit  = 1'b0;
        qry_data = wr_data;
        if (qry_reg != 5'd0) begin
            if (wr_en && (wr_reg == qry_reg))
                qry_hit = 1'b1;
            // Walk oldest to youngest so the last match wins
            for (int k = 0; k < DEPTH; k++) begin
                if ((3'(k) < count) && (fifo_rd[rptr + PW'(k)] == qry_reg)) begin
                    qry_hit  = 1'b1;
                    qry_data = fifo_data[rptr + PW'(k)];
                end
            end
        end
    end
`else
    logic unused_qry;
    assign unused_qry = ^qry_reg;
    assign qry_hit    = 1'b0;
    assign qry_data   = 32'd0;
`endif

endmodule
